// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote sampling,
// runtime baud divisor, frame/parity/overrun detection and a show-ahead FIFO.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data).
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OS_RATE    = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned OS_W  = $clog2(OS_RATE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned SP0   = OS_RATE / 2 - 1;
  localparam int unsigned SP1   = OS_RATE / 2;
  localparam int unsigned SP2   = OS_RATE / 2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_d;
  logic [DIV_W-1:0]     r_tick_cnt;
  logic [OS_W-1:0]      r_os_cnt;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_busy;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_sp_last;
  logic w_maj;
  logic w_start;
  logic w_shift;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_frame_err;
  logic w_overrun;

`ifdef UART_RX_PARITY_EN
  logic r_par_latched;
  logic r_parity_err;
  logic w_par_set;
  logic w_par_pulse;
`else
  logic w_unused_par;
  assign w_unused_par = 1'(PARITY_ODD);
`endif

  assign w_rx      = r_sync2;
  assign w_fall    = r_rx_d & ~r_sync2;
  assign w_tick    = (r_tick_cnt == '0);
  assign w_sp_last = w_tick && (r_os_cnt == OS_W'(SP2));
  assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & rx_ready;

  assign rx_valid  = ~w_empty;
  assign rx_data   = r_mem[r_rd_ptr[AW-1:0]];
  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Oversample tick down-counter; divisor picked up on every reload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_start || w_tick) begin
      r_tick_cnt <= baud_div;
    end else begin
      r_tick_cnt <= r_tick_cnt - DIV_W'(1);
    end
  end

  // Oversample position within the bit and the two early majority samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_os_cnt <= '0;
      r_samp   <= 2'b11;
    end else if (w_start || (r_state == S_IDLE)) begin
      r_os_cnt <= '0;
    end else if (w_tick) begin
      r_os_cnt <= (r_os_cnt == OS_W'(OS_RATE - 1)) ? '0 : r_os_cnt + OS_W'(1);
      if (r_os_cnt == OS_W'(SP0)) r_samp[0] <= w_rx;
      if (r_os_cnt == OS_W'(SP1)) r_samp[1] <= w_rx;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // FSM next state and per-cycle control decisions
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    w_overrun   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_set   = 1'b0;
    w_par_pulse = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_start     = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_sp_last) w_state_nxt = w_maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_sp_last) begin
          w_shift = 1'b1;
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sp_last) begin
          w_par_set   = (^r_shift) ^ w_maj ^ 1'(PARITY_ODD);
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_sp_last) begin
          w_state_nxt = S_IDLE;
          if (!w_maj) begin
            w_frame_err = 1'b1;
          end else if (!w_full || w_pop) begin
            w_push = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_par_pulse = r_par_latched;
`endif
          end else begin
            w_overrun = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Data shift register, bit counter and error pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_latched <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= w_par_pulse;
      if (w_start) r_par_latched <= 1'b0;
      else if (w_par_set) r_par_latched <= 1'b1;
`endif
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
    end
  end

  // Show-ahead receive FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: 8-bit frames, baud_div=4, OS_RATE=16.
module tb_uart_rx_os;

  localparam int unsigned BIT_CLKS = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_busy;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;
  int cnt_fe = 0, cnt_pe = 0, cnt_ov = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  logic [7:0] exp_q[$];

  uart_rx_os dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(par);
`else
    if (par === 1'bx) $display("parity argument unused");
`endif
    hold_bit(stop);
    rx = 1'b1;
  endtask

  // Pops the scoreboard whenever a byte is handed over; counts error pulse cycles
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (frame_err)  cnt_fe++;
        if (parity_err) cnt_pe++;
        if (overrun)    cnt_ov++;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_data unexpected: got 0x%0h expected none", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", int'(rx_data), int'(e));
          end
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    baud_div = 16'd4;
    fork
      monitor();
    join_none

    clks(3);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset rx_data", int'(rx_data), 0);
    check("reset rx_busy", int'(rx_busy), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset parity_err", int'(parity_err), 0);
    check("reset overrun", int'(overrun), 0);
    rst = 1'b1;
    clks(10);

    // Plain byte, busy seen mid-frame
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        clks(200);
        check("busy mid-frame", int'(rx_busy), 1);
      end
    join
    clks(100);
    check("A5 drained", exp_q.size(), 0);
    check("A5 rx_valid", int'(rx_valid), 0);

    // Short low glitch is a false start
    rx = 1'b0;
    clks(16);
    rx = 1'b1;
    clks(10);
    check("glitch busy early", int'(rx_busy), 1);
    clks(100);
    check("glitch busy end", int'(rx_busy), 0);
    check("glitch rx_valid", int'(rx_valid), 0);

    // Bad stop bit, then a good frame
    exp_fe++;
    send_frame(8'h3C, 1'b0, 1'b0);
    clks(BIT_CLKS);
    check("frame_err count", cnt_fe, exp_fe);
    check("frame_err rx_valid", int'(rx_valid), 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1);
    clks(100);

    // FIFO overrun on the fifth back-to-back byte
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i <= 4) exp_q.push_back(b);
      else exp_ov++;
      send_frame(b, ^b, 1'b1);
      if (i == 4) check("overrun before 5th", cnt_ov, 0);
    end
    clks(2 * BIT_CLKS);
    check("overrun count", cnt_ov, exp_ov);
    check("full rx_valid", int'(rx_valid), 1);
    check("full head", int'(rx_data), 8'h01);
    rx_ready = 1'b1;
    clks(20);
    check("drain done", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x03 needs parity bit 0
    exp_pe++;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b1);
    clks(100);
    check("parity_err bad", cnt_pe, exp_pe);
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b0, 1'b1);
    clks(100);
    check("parity_err good", cnt_pe, exp_pe);
`endif

    // Reset in the middle of the data bits
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    hold_bit(1'b0);
    check("busy before reset", int'(rx_busy), 1);
    rst = 1'b0;
    clks(3);
    rx = 1'b1;
    check("busy in reset", int'(rx_busy), 0);
    check("valid in reset", int'(rx_valid), 0);
    rst = 1'b1;
    clks(10);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, ^8'h7E, 1'b1);
    clks(200);

    check("final queue empty", exp_q.size(), 0);
    check("final frame_err", cnt_fe, exp_fe);
    check("final parity_err", cnt_pe, exp_pe);
    check("final overrun", cnt_ov, exp_ov);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
